// File: rtl/audio_pkg.sv
// Shared types and word-length helpers for the playback mixer.
// Pure definitions, no state.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        SATURATE,
        PRESENT
    } mix_state_t;

    localparam logic [1:0] WL_16 = 2'b00;
    localparam logic [1:0] WL_20 = 2'b01;
    localparam logic [1:0] WL_24 = 2'b10;
    localparam logic [1:0] WL_32 = 2'b11;

    function automatic int unsigned wl_bits(input logic [1:0] wl);
        case (wl)
            WL_16:   return 16;
            WL_20:   return 20;
            WL_24:   return 24;
            default: return 32;
        endcase
    endfunction

    // Sign-extends the low word-length bits of a sample; upper bits are ignored.
    function automatic logic [31:0] sext_wl(input logic [31:0] d, input logic [1:0] wl);
        case (wl)
            WL_16:   return {{16{d[15]}}, d[15:0]};
            WL_20:   return {{12{d[19]}}, d[19:0]};
            WL_24:   return {{8{d[23]}}, d[23:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/audio_sat_clamp.sv
// Clamps one wide signed accumulator to the active word length, sign-extended to 32 bits.
// Purely combinational; no flow control.
module audio_sat_clamp #(
    parameter int ACC_W = 35
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic [1:0]              wl_i,
    output logic [31:0]             dat_o
);
    import audio_pkg::*;

    logic [31:0]             lim32;
    logic [31:0]             max32;
    logic [31:0]             min32;
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;

    always_comb begin
        // 2^(W-1); for W=32 this is 0x80000000, whose negation is itself.
        lim32 = 32'h1 << (wl_bits(wl_i) - 1);
        max32 = lim32 - 32'h1;
        min32 = -lim32;
        max_v = {{(ACC_W-32){max32[31]}}, max32};
        min_v = {{(ACC_W-32){min32[31]}}, min32};
        if (acc_i > max_v) begin
            dat_o = max32;
        end else if (acc_i < min_v) begin
            dat_o = min32;
        end else begin
            dat_o = acc_i[31:0];
        end
    end

endmodule

// File: rtl/audio_mix_scheduler.sv
// Per-frame mixer: polls NUM_SRC producers after each frame sync, sums, saturates, presents one frame.
// out_tvalid at NUM_SRC+2 cycles after sync; an unaccepted frame is dropped by the next sync.
module audio_mix_scheduler #(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 16
) (
    input  logic                  ac_bclk,
    input  logic                  reset,
    input  logic                  ac_pblrc,
    input  logic                  enable,
    input  logic [1:0]            word_length,
    input  logic [NUM_SRC-1:0]    src_mask,
    input  logic [NUM_SRC-1:0]    src_tvalid,
    input  logic [NUM_SRC*64-1:0] src_tdata,
    output logic [NUM_SRC-1:0]    src_tready,
    output logic                  out_tvalid,
    output logic [63:0]           out_tdata,
    input  logic                  out_tready,
    output logic [NUM_SRC-1:0]    underrun_sticky,
    input  logic                  underrun_clr,
    output logic [CNT_W-1:0]      overrun_count
);
    import audio_pkg::*;

    localparam int ACC_W = 32 + $clog2(NUM_SRC) + 1;
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    mix_state_t              state_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    pblrc_q;
    logic [1:0]              wl_q;
    logic [NUM_SRC-1:0]      mask_q;
    logic signed [ACC_W-1:0] acc_l_q, acc_r_q;
    logic signed [ACC_W-1:0] acc_l_d, acc_r_d;
    logic                    out_tvalid_q;
    logic [63:0]             out_tdata_q;
    logic [NUM_SRC-1:0]      under_q, under_d;
    logic [CNT_W-1:0]        ovr_q;

    logic [63:0]        src_dat [NUM_SRC];
    logic [63:0]        sel_dat;
    logic [31:0]        samp_l, samp_r;
    logic [31:0]        sat_l, sat_r;
    logic [NUM_SRC-1:0] tready_pulse;
    logic               frame_start, take, miss, start_frame, ovr_inc;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_dat[g] = src_tdata[g*64 +: 64];
    end

    always_comb begin
        frame_start = ac_pblrc & ~pblrc_q;
        sel_dat     = src_dat[idx_q];
        take        = (state_q == COLLECT) & mask_q[idx_q] & src_tvalid[idx_q];
        miss        = (state_q == COLLECT) & mask_q[idx_q] & ~src_tvalid[idx_q];
        samp_l      = take ? sext_wl(sel_dat[31:0], wl_q) : 32'h0;
        samp_r      = take ? sext_wl(sel_dat[63:32], wl_q) : 32'h0;
        acc_l_d     = acc_l_q + {{(ACC_W-32){samp_l[31]}}, samp_l};
        acc_r_d     = acc_r_q + {{(ACC_W-32){samp_r[31]}}, samp_r};
        tready_pulse = '0;
        if (take) tready_pulse[idx_q] = 1'b1;
        // A new underrun outranks a simultaneous clear.
        under_d = under_q & ~{NUM_SRC{underrun_clr}};
        if (miss) under_d[idx_q] = 1'b1;
        start_frame = frame_start & ((state_q == IDLE) | (state_q == PRESENT));
        ovr_inc     = frame_start & ((state_q == COLLECT) | (state_q == SATURATE) |
                                     ((state_q == PRESENT) & ~out_tready));
    end

    audio_sat_clamp #(.ACC_W(ACC_W)) u_clamp_l (.acc_i(acc_l_q), .wl_i(wl_q), .dat_o(sat_l));
    audio_sat_clamp #(.ACC_W(ACC_W)) u_clamp_r (.acc_i(acc_r_q), .wl_i(wl_q), .dat_o(sat_r));

    always_ff @(posedge ac_bclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pblrc_q      <= 1'b1;
            wl_q         <= WL_16;
            mask_q       <= '0;
            acc_l_q      <= '0;
            acc_r_q      <= '0;
            out_tvalid_q <= 1'b0;
            out_tdata_q  <= '0;
            under_q      <= '0;
            ovr_q        <= '0;
        end else begin
            pblrc_q <= ac_pblrc;
            under_q <= under_d;
            if (ovr_inc && (ovr_q != {CNT_W{1'b1}})) ovr_q <= ovr_q + CNT_W'(1);
            if (start_frame) begin
                wl_q         <= word_length;
                mask_q       <= src_mask;
                acc_l_q      <= '0;
                acc_r_q      <= '0;
                idx_q        <= '0;
                out_tvalid_q <= 1'b0;
                state_q      <= enable ? COLLECT : SATURATE;
            end else begin
                case (state_q)
                    COLLECT: begin
                        acc_l_q <= acc_l_d;
                        acc_r_q <= acc_r_d;
                        if (idx_q == IDX_W'(NUM_SRC - 1)) begin
                            state_q <= SATURATE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                    SATURATE: begin
                        out_tdata_q  <= {sat_r, sat_l};
                        out_tvalid_q <= 1'b1;
                        state_q      <= PRESENT;
                    end
                    PRESENT: begin
                        if (out_tready) begin
                            out_tvalid_q <= 1'b0;
                            state_q      <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign src_tready      = tready_pulse;
    assign out_tvalid      = out_tvalid_q;
    assign out_tdata       = out_tdata_q;
    assign underrun_sticky = under_q;
    assign overrun_count   = ovr_q;

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Self-checking bench for audio_mix_scheduler: fixed vector table, corner sequences, randomized frames.
module tb_audio_mix_scheduler;
    localparam int N = 4;

    typedef struct packed {
        logic              en;
        logic [1:0]        wl;
        logic [N-1:0]      mask;
        logic [N-1:0]      valid;
        logic [N-1:0][31:0] l;
        logic [N-1:0][31:0] r;
        logic [63:0]       exp_dat;
    } vec_t;

    logic            ac_bclk = 1'b0;
    logic            reset = 1'b1;
    logic            ac_pblrc = 1'b1;
    logic            enable = 1'b0;
    logic [1:0]      word_length = 2'd0;
    logic [N-1:0]    src_mask = '0;
    logic [N-1:0]    src_tvalid = '0;
    logic [N*64-1:0] src_tdata = '0;
    logic [N-1:0]    src_tready;
    logic            out_tvalid;
    logic [63:0]     out_tdata;
    logic            out_tready = 1'b0;
    logic [N-1:0]    underrun_sticky;
    logic            underrun_clr = 1'b0;
    logic [15:0]     overrun_count;

    audio_mix_scheduler #(.NUM_SRC(N), .CNT_W(16)) dut (
        .ac_bclk(ac_bclk), .reset(reset), .ac_pblrc(ac_pblrc), .enable(enable),
        .word_length(word_length), .src_mask(src_mask), .src_tvalid(src_tvalid),
        .src_tdata(src_tdata), .src_tready(src_tready), .out_tvalid(out_tvalid),
        .out_tdata(out_tdata), .out_tready(out_tready), .underrun_sticky(underrun_sticky),
        .underrun_clr(underrun_clr), .overrun_count(overrun_count)
    );

    always #5 ac_bclk = ~ac_bclk;

    int n_vec = 0;
    int n_bad = 0;

    logic               st_en;
    logic [1:0]         st_wl;
    logic [N-1:0]       st_mask, st_valid;
    logic [N-1:0][31:0] st_l, st_r;
    logic [N-1:0]       exp_under = '0;
    vec_t               tbl [8];

    task automatic tick();
        @(posedge ac_bclk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic [1:0] wl, input logic [3:0] mask,
                                input logic [3:0] valid, input logic [31:0] l0, input logic [31:0] l1,
                                input logic [31:0] l2, input logic [31:0] l3, input logic [31:0] r0,
                                input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3,
                                input logic [63:0] exp_dat);
        vec_t v;
        v.en = en; v.wl = wl; v.mask = mask; v.valid = valid;
        v.l[0] = l0; v.l[1] = l1; v.l[2] = l2; v.l[3] = l3;
        v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
        v.exp_dat = exp_dat;
        return v;
    endfunction

    task automatic load(input vec_t v);
        st_en = v.en; st_wl = v.wl; st_mask = v.mask; st_valid = v.valid;
        st_l = v.l; st_r = v.r;
    endtask

    task automatic drive_stim();
        enable = st_en; word_length = st_wl; src_mask = st_mask; src_tvalid = st_valid;
        for (int i = 0; i < N; i++) src_tdata[i*64 +: 64] = {st_r[i], st_l[i]};
    endtask

    // Reference: sum the sign-extended W-bit samples of polled sources, then clamp to W bits.
    function automatic logic [31:0] ref_chan(input logic [N-1:0][31:0] s);
        longint w, lim, sum, u;
        case (st_wl)
            2'd0:    w = 16;
            2'd1:    w = 20;
            2'd2:    w = 24;
            default: w = 32;
        endcase
        lim = longint'(1) << (w - 1);
        sum = 0;
        for (int i = 0; i < N; i++) begin
            if (st_en && st_mask[i] && st_valid[i]) begin
                u = longint'({32'd0, s[i]}) & ((longint'(1) << w) - 1);
                if (u >= lim) u = u - 2 * lim;
                sum = sum + u;
            end
        end
        if (sum > lim - 1) sum = lim - 1;
        else if (sum < -lim) sum = -lim;
        return sum[31:0];
    endfunction

    function automatic logic [63:0] ref_frame();
        return {ref_chan(st_r), ref_chan(st_l)};
    endfunction

    task automatic pulse_fs();
        ac_pblrc = 1'b1;
        tick();
        ac_pblrc = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        while (!out_tvalid && k < 20) begin
            tick();
            k++;
        end
        check({nm, " tvalid"}, 64'(out_tvalid), 64'd1);
    endtask

    task automatic accept();
        out_tready = 1'b1;
        tick();
        out_tready = 1'b0;
    endtask

    task automatic clear_under();
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        exp_under = '0;
    endtask

    task automatic do_frame(input string nm, input logic [63:0] exp_dat);
        int lat;
        logic [N-1:0] exp_rdy;
        drive_stim();
        pulse_fs();
        lat = 1;
        if (st_en) begin
            for (int i = 0; i < N; i++) begin
                exp_rdy = '0;
                if (st_mask[i] && st_valid[i]) exp_rdy[i] = 1'b1;
                check({nm, " tready"}, 64'(src_tready), 64'(exp_rdy));
                tick();
                lat++;
            end
        end else begin
            check({nm, " tready idle"}, 64'(src_tready), 64'd0);
        end
        while (!out_tvalid && lat < 20) begin
            tick();
            lat++;
        end
        check({nm, " latency"}, 64'(lat), st_en ? 64'(N + 2) : 64'd2);
        check({nm, " data"}, out_tdata, exp_dat);
        if (st_en) exp_under = exp_under | (st_mask & ~st_valid);
        check({nm, " underrun"}, 64'(underrun_sticky), 64'(exp_under));
        accept();
        check({nm, " tvalid drop"}, 64'(out_tvalid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] seen;
        int lat;

        tbl[0] = mk(1, 2'd0, 4'hF, 4'hF, 32'h1000, 32'h1000, 32'h1000, 32'h1000,
                    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFC, 32'h00004000});
        tbl[1] = mk(1, 2'd0, 4'hF, 4'hF, 32'h7FFF, 32'h7FFF, 32'h0, 32'h0,
                    32'h8000, 32'h8000, 32'h0, 32'h0, {32'hFFFF8000, 32'h00007FFF});
        tbl[2] = mk(1, 2'd2, 4'b1011, 4'b1101, 32'h1, 32'h2, 32'h4, 32'h8,
                    32'h10, 32'h20, 32'h40, 32'h80, {32'h00000090, 32'h00000009});
        tbl[3] = mk(0, 2'd0, 4'hF, 4'hF, 32'h1234, 32'h5678, 32'h9ABC, 32'hDEF0,
                    32'h1, 32'h2, 32'h3, 32'h4, 64'h0);
        tbl[4] = mk(1, 2'd1, 4'b0011, 4'b0011, 32'h7FFFF, 32'h7FFFF, 32'h12345, 32'h12345,
                    32'hABC80000, 32'h0, 32'h0, 32'h0, {32'hFFF80000, 32'h0007FFFF});
        tbl[5] = mk(1, 2'd3, 4'hF, 4'hF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0,
                    32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, {32'h80000000, 32'h7FFFFFFF});
        tbl[6] = mk(1, 2'd2, 4'hF, 4'hF, 32'h00123456, 32'hFFFFFFFF, 32'h00800000, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0, {32'h00000000, 32'hFF923455});
        tbl[7] = mk(1, 2'd0, 4'b0101, 4'hF, 32'hDEAD0001, 32'h5555, 32'hBEEFFFFE, 32'h5555,
                    32'h00017FFF, 32'h0, 32'h00000001, 32'h0, {32'h00007FFF, 32'hFFFFFFFF});

        // Reset values, then a high frame sync at reset release must not count as an edge.
        repeat (3) tick();
        check("rst tvalid", 64'(out_tvalid), 64'd0);
        check("rst tdata", out_tdata, 64'd0);
        check("rst tready", 64'(src_tready), 64'd0);
        check("rst underrun", 64'(underrun_sticky), 64'd0);
        check("rst overrun", 64'(overrun_count), 64'd0);
        enable = 1'b1; src_mask = '1; src_tvalid = '1;
        reset = 1'b0;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | src_tready;
            seen[0] = seen[0] | out_tvalid;
        end
        check("no edge at release", 64'(seen), 64'd0);
        ac_pblrc = 1'b0;
        tick();

        foreach (tbl[i]) begin
            clear_under();
            load(tbl[i]);
            do_frame($sformatf("vec%0d", i), tbl[i].exp_dat);
        end

        // Clear and a new underrun in the same cycle: the set wins.
        clear_under();
        load(tbl[2]);
        drive_stim();
        pulse_fs();
        tick();
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("clr race underrun", 64'(underrun_sticky), 64'b0010);
        wait_valid("clr race");
        check("clr race data", out_tdata, tbl[2].exp_dat);
        accept();
        clear_under();
        check("clr idle underrun", 64'(underrun_sticky), 64'd0);

        // Overrun: held frame is dropped by the next sync and fresh data follows.
        load(tbl[0]);
        drive_stim();
        pulse_fs();
        wait_valid("ovr first");
        repeat (2) tick();
        check("ovr held tvalid", 64'(out_tvalid), 64'd1);
        check("ovr held data", out_tdata, tbl[0].exp_dat);
        load(tbl[5]);
        drive_stim();
        pulse_fs();
        check("ovr count", 64'(overrun_count), 64'd1);
        check("ovr stale dropped", 64'(out_tvalid), 64'd0);
        check("ovr restart tready", 64'(src_tready), 64'b0001);
        wait_valid("ovr second");
        check("ovr fresh data", out_tdata, tbl[5].exp_dat);
        accept();

        // Accept and frame sync in the same cycle: no drop, collection still starts.
        load(tbl[6]);
        drive_stim();
        pulse_fs();
        wait_valid("acc-win first");
        load(tbl[1]);
        drive_stim();
        out_tready = 1'b1;
        pulse_fs();
        out_tready = 1'b0;
        check("acc-win overrun", 64'(overrun_count), 64'd1);
        check("acc-win tvalid", 64'(out_tvalid), 64'd0);
        check("acc-win tready", 64'(src_tready), 64'b0001);
        wait_valid("acc-win second");
        check("acc-win data", out_tdata, tbl[1].exp_dat);
        accept();

        // Frame sync during COLLECT is ignored but counted.
        load(tbl[0]);
        drive_stim();
        pulse_fs();
        tick();
        pulse_fs();
        check("collect sync overrun", 64'(overrun_count), 64'd2);
        lat = 3;
        while (!out_tvalid && lat < 20) begin
            tick();
            lat++;
        end
        check("collect sync latency", 64'(lat), 64'(N + 2));
        check("collect sync data", out_tdata, tbl[0].exp_dat);
        accept();
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | src_tready;
            seen[0] = seen[0] | out_tvalid;
        end
        check("collect sync no restart", 64'(seen), 64'd0);

        // Reset mid-COLLECT aborts at once; the next frame mixes normally.
        load(tbl[0]);
        drive_stim();
        pulse_fs();
        tick();
        reset = 1'b1;
        #1;
        check("midrst tready", 64'(src_tready), 64'd0);
        check("midrst tvalid", 64'(out_tvalid), 64'd0);
        check("midrst tdata", out_tdata, 64'd0);
        check("midrst overrun", 64'(overrun_count), 64'd0);
        check("midrst underrun", 64'(underrun_sticky), 64'd0);
        tick();
        reset = 1'b0;
        exp_under = '0;
        tick();
        do_frame("post-rst", tbl[0].exp_dat);

        // Randomized frames against the reference model.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) clear_under();
            st_en    = ($urandom_range(0, 5) != 0);
            st_wl    = 2'($urandom_range(0, 3));
            st_mask  = N'($urandom);
            st_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                st_l[i] = $urandom;
                st_r[i] = $urandom;
            end
            do_frame($sformatf("rand%0d", f), ref_frame());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
